// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between the two command front-ends and the shared
// adder-subtractor arbiter. The arbiter takes the slave side.
interface addsub_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       req1_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_s;
  logic       rsp_ovf;
  logic       rsp_neg;
  logic       busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_s, rsp_ovf, rsp_neg, busy,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_s, rsp_ovf, rsp_neg, busy,
    output rsp_ready
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 8-bit adder-subtractor between two requesters;
// one operation in flight, registered response with backpressure.
module addsub_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  addsub_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
  } req_t;

  state_e                    state_q;
  logic                      prio_q;
  req_t                      op_q;
  logic                      id_q;
  logic                      rsp_valid_q;
  logic                      rsp_id_q;
  logic [7:0]                rsp_s_q;
  logic                      rsp_ovf_q;
  logic                      rsp_neg_q;
  logic                      busy_q;

  logic [NUM_REQ-1:0]        vld;
  req_t [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        gnt;
  logic                      gnt_id;
  logic [7:0]                dp_s;
  logic                      dp_ovf;
  logic                      dp_neg;

  always_comb begin
    vld    = {bus.req1_valid, bus.req0_valid};
    req[0] = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op};
    req[1] = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op};
    // A lone requester always wins; on contention the priority holder does.
    gnt[0] = vld[0] & (~vld[1] | ~prio_q);
    gnt[1] = vld[1] & (~vld[0] |  prio_q);
    gnt_id = gnt[1];
  end

  assign bus.req0_ready = (state_q == IDLE) & gnt[0];
  assign bus.req1_ready = (state_q == IDLE) & gnt[1];

  // The datapath's sub pin is active-low, hence the inversion.
  AddSub u_addsub (
    .A_in  (op_q.a),
    .B_in  (op_q.b),
    .sub   (~op_q.op),
    .s_o   (dp_s),
    .ovf_o (dp_ovf),
    .neg_o (dp_neg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= RR_INIT;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_s_q     <= 8'h00;
      rsp_ovf_q   <= 1'b0;
      rsp_neg_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            op_q    <= req[gnt_id];
            id_q    <= gnt_id;
            prio_q  <= ~gnt_id;
            state_q <= EXEC;
            busy_q  <= 1'b1;
          end
        end
        EXEC: begin
          rsp_s_q     <= dp_s;
          rsp_ovf_q   <= dp_ovf;
          rsp_neg_q   <= dp_neg;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_s     = rsp_s_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_neg   = rsp_neg_q;
  assign bus.busy      = busy_q;
endmodule

// 8-bit two's-complement adder-subtractor. sub=0 computes A-B by adding the
// two's complement of B, so A-0x80 degenerates to A+0x80.
module AddSub (
  input  logic [7:0] A_in,
  input  logic [7:0] B_in,
  input  logic       sub,
  output logic [7:0] s_o,
  output logic       ovf_o,
  output logic       neg_o
);
  logic [7:0] n;
  logic [8:0] sum;

  always_comb begin
    n     = sub ? B_in : (~B_in + 8'd1);
    sum   = {A_in[7], A_in} + {n[7], n};
    s_o   = sum[7:0];
    ovf_o = sum[8] ^ sum[7];
    neg_o = sum[7];
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized and directed bench for addsub_arbiter against a cycle-level
// behavioural model of the arbitration and signed arithmetic.
module tb_addsub_arbiter;
  localparam bit RR = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_arbiter_if bus();

  addsub_arbiter #(.RR_INIT(RR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed arithmetic as plain integers: subtraction adds N=(256-B) mod 256
  // read back as a signed byte.
  task automatic calc(input logic [7:0] a, input logic [7:0] b, input logic op,
                      output logic [7:0] s, output logic ov, output logic ng);
    int av, bv, sum;
    logic [7:0] n;
    n   = op ? 8'(256 - int'(b)) : b;
    av  = (a > 8'd127) ? int'(a) - 256 : int'(a);
    bv  = (n > 8'd127) ? int'(n) - 256 : int'(n);
    sum = av + bv;
    s   = 8'(sum);
    ov  = (sum > 127) || (sum < -128);
    ng  = s[7];
  endtask

  // Model: phase 0 = waiting for work, 1 = computing, 2 = holding a result.
  int         m_phase = 0;
  logic       m_prio  = RR;
  logic       m_rv    = 1'b0;
  logic [7:0] m_s     = 8'h00;
  logic       m_ov    = 1'b0;
  logic       m_ng    = 1'b0;
  logic       m_id    = 1'b0;
  logic [7:0] p_a, p_b;
  logic       p_op, p_id;

  always @(negedge clk) begin
    logic v0, v1, e0, e1;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    e0 = 1'b0;
    e1 = 1'b0;
    if (m_phase == 0) begin
      if (v0 && v1) begin
        e0 = (m_prio == 1'b0);
        e1 = (m_prio == 1'b1);
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    chk("busy", bus.busy, m_phase != 0);
    chk("rsp_valid", bus.rsp_valid, m_rv);
    if (m_rv) begin
      chk("rsp_s", bus.rsp_s, m_s);
      chk("rsp_ovf", bus.rsp_ovf, m_ov);
      chk("rsp_neg", bus.rsp_neg, m_ng);
      chk("rsp_id", bus.rsp_id, m_id);
    end
    // Advance to the state the coming rising edge produces.
    if (!rst_n) begin
      m_phase = 0; m_prio = RR; m_rv = 0;
      m_s = 8'h00; m_ov = 0; m_ng = 0; m_id = 0;
    end else if (m_phase == 0) begin
      if (e0 || e1) begin
        p_id  = e1;
        p_a   = e1 ? bus.req1_a  : bus.req0_a;
        p_b   = e1 ? bus.req1_b  : bus.req0_b;
        p_op  = e1 ? bus.req1_op : bus.req0_op;
        m_prio = ~p_id;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      calc(p_a, p_b, p_op, m_s, m_ov, m_ng);
      m_id = p_id;
      m_rv = 1'b1;
      m_phase = 2;
    end else if (bus.rsp_ready) begin
      m_rv = 1'b0;
      m_phase = 0;
    end
  end

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'hFF;
      3: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b, input logic op,
                       input logic [7:0] es, input logic eo, input logic en, input string nm);
    logic got;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = id ? bus.req1_ready : bus.req0_ready;
    end
    chk({nm, " accept"}, got, 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk({nm, " busy T+1"}, bus.busy, 1'b1);
    chk({nm, " no rsp T+1"}, bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk({nm, " rsp_valid T+2"}, bus.rsp_valid, 1'b1);
    chk({nm, " busy T+2"}, bus.busy, 1'b1);
    chk({nm, " s"}, bus.rsp_s, es);
    chk({nm, " ovf"}, bus.rsp_ovf, eo);
    chk({nm, " neg"}, bus.rsp_neg, en);
    chk({nm, " id"}, bus.rsp_id, id);
  endtask

  initial begin
    logic [7:0] s0;
    logic       acc0, acc1;
    logic       ids[$];

    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    bus.rsp_ready  = 0;

    @(negedge clk);
    chk("reset rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset rsp_s", bus.rsp_s, 8'h00);
    chk("reset ovf", bus.rsp_ovf, 1'b0);
    chk("reset neg", bus.rsp_neg, 1'b0);
    chk("reset id", bus.rsp_id, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(1'b0, 8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b0, "sub5-3");
    do_op(1'b1, 8'h70, 8'h20, 1'b0, 8'h90, 1'b1, 1'b1, "add_ovf");
    do_op(1'b0, 8'hFE, 8'h02, 1'b1, 8'hFC, 1'b0, 1'b1, "subFE-2");
    do_op(1'b1, 8'h00, 8'h80, 1'b1, 8'h80, 1'b0, 1'b1, "sub0-80");

    // Fairness from a fresh reset with both requesters always pending.
    do_reset();
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h01; bus.req0_op = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h02; bus.req1_b = 8'h01; bus.req1_op = 1'b1;
    for (int c = 0; c < 40 && ids.size() < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) ids.push_back(bus.rsp_id);
    end
    chk("fair count", ids.size(), 4);
    for (int i = 0; i < ids.size(); i++) chk("fair id", ids[i], i % 2);

    // Backpressure: result frozen, no grants while held.
    do_reset();
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h7F; bus.req0_b = 8'h01; bus.req0_op = 1'b0;
    for (int c = 0; c < 20 && !bus.rsp_valid; c++) @(negedge clk);
    chk("bp rsp_valid", bus.rsp_valid, 1'b1);
    bus.req1_valid = 1'b1; bus.req1_a = 8'h11; bus.req1_b = 8'h22; bus.req1_op = 1'b0;
    s0 = bus.rsp_s;
    chk("bp s", s0, 8'h80);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp hold s", bus.rsp_s, 8'h80);
      chk("bp hold ovf", bus.rsp_ovf, 1'b1);
      chk("bp ready0", bus.req0_ready, 1'b0);
      chk("bp ready1", bus.req1_ready, 1'b0);
      chk("bp busy", bus.busy, 1'b1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release valid", bus.rsp_valid, 1'b1);
    @(negedge clk);
    chk("bp done valid", bus.rsp_valid, 1'b0);
    chk("bp done busy", bus.busy, 1'b0);

    // Reset during EXEC discards the operation and restores priority.
    do_reset();
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h10; bus.req0_b = 8'h10; bus.req0_op = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("rst accept", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("rst in exec busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst prio ready0", bus.req0_ready, 1'b1);
    chk("rst prio ready1", bus.req1_ready, 1'b0);

    // Random traffic with occasional resets; the model checks every cycle.
    do_reset();
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 79) != 0);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = $urandom_range(0, 1);
        bus.req0_a = rnd8(); bus.req0_b = rnd8(); bus.req0_op = $urandom_range(0, 1);
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = $urandom_range(0, 1);
        bus.req1_a = rnd8(); bus.req1_b = rnd8(); bus.req1_op = $urandom_range(0, 1);
      end
      @(negedge clk);
      acc0 = bus.req0_valid & bus.req0_ready & rst_n;
      acc1 = bus.req1_valid & bus.req1_ready & rst_n;
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
